// File: rtl/xorwow_arbiter.sv
// Shares one xorwow core between N_REQ requesters: sequences the seed load, steps the core
// on a round-robin grant and hands the resulting word to the winner.
module xorwow_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SEED = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              seed_start_i,
  input  logic [DATA_W-1:0] seed_word_i,
  output logic [2:0]        seed_idx_o,
  output logic              core_load_o,
  output logic              core_step_o,
  input  logic [DATA_W-1:0] core_rand_i,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              seeded_o,
  output logic              busy_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] StUnseeded = 3'd0;
  localparam logic [2:0] StSeed     = 3'd1;
  localparam logic [2:0] StIdle     = 3'd2;
  localparam logic [2:0] StStep     = 3'd3;
  localparam logic [2:0] StDeliver  = 3'd4;

  localparam logic [2:0]       LastSeedIdx = 3'(N_SEED - 1);
  localparam logic [IdxW-1:0]  LastReq     = IdxW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] OneHot0     = N_REQ'(1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        seed_idx_q, seed_idx_d;
  logic              seeded_q, seeded_d;
  logic              pending_q, pending_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand;

  // The seed word goes straight from the register file into the core; it is not used here.
  logic unused_seed_word;
  assign unused_seed_word = ^seed_word_i;

  // Round-robin search starting one past the last winner, wrapping at N_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % N_REQ);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    seed_idx_d = seed_idx_q;
    seeded_d   = seeded_q;
    pending_d  = pending_q;
    winner_d   = winner_q;
    last_d     = last_q;
    rdata_d    = rdata_q;
    case (state_q)
      StUnseeded: begin
        if (seed_start_i) begin
          state_d    = StSeed;
          seed_idx_d = '0;
        end
      end
      StSeed: begin
        if (seed_idx_q == LastSeedIdx) begin
          state_d    = StIdle;
          seeded_d   = 1'b1;
          seed_idx_d = '0;
        end else begin
          seed_idx_d = seed_idx_q + 3'd1;
        end
      end
      StIdle: begin
        // A reseed, whether fresh or left pending from a transfer, beats any request.
        if (seed_start_i || pending_q) begin
          state_d    = StSeed;
          seed_idx_d = '0;
          pending_d  = 1'b0;
        end else if (pick_valid) begin
          state_d  = StStep;
          winner_d = pick_idx;
        end
      end
      StStep: begin
        state_d = StDeliver;
        if (seed_start_i) pending_d = 1'b1;
      end
      StDeliver: begin
        state_d = StIdle;
        rdata_d = core_rand_i;
        last_d  = winner_q;
        if (seed_start_i) pending_d = 1'b1;
      end
      default: begin
        state_d = StUnseeded;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StUnseeded;
      seed_idx_q <= '0;
      seeded_q   <= 1'b0;
      pending_q  <= 1'b0;
      winner_q   <= '0;
      last_q     <= LastReq;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      seed_idx_q <= seed_idx_d;
      seeded_q   <= seeded_d;
      pending_q  <= pending_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs decode the current state only, so reset clears them without waiting for a clock.
  always_comb begin
    core_load_o = (state_q == StSeed);
    core_step_o = (state_q == StStep);
    rvalid_o    = (state_q == StDeliver);
    seed_idx_o  = seed_idx_q;
    gnt_o       = rvalid_o ? (OneHot0 << winner_q) : '0;
    rdata_o     = rvalid_o ? core_rand_i : rdata_q;
    seeded_o    = seeded_q;
    busy_o      = (state_q != StUnseeded) && (state_q != StIdle);
  end

endmodule

// File: tb/tb_xorwow_arbiter.sv
// Self-checking bench for xorwow_arbiter: cycle-level transaction model plus directed
// literal checks and a randomized phase with reseeds and asynchronous resets.
module tb_xorwow_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NS = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         seed_start;
  logic [W-1:0] seed_word;
  logic [2:0]   seed_idx;
  logic         core_load;
  logic         core_step;
  logic [W-1:0] core_rand = '0;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         seeded;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  xorwow_arbiter #(.N_REQ(N), .DATA_W(W), .N_SEED(NS)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .seed_start_i(seed_start),
    .seed_word_i (seed_word),
    .seed_idx_o  (seed_idx),
    .core_load_o (core_load),
    .core_step_o (core_step),
    .core_rand_i (core_rand),
    .req_i       (req),
    .gnt_o       (gnt),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .seeded_o    (seeded),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  assign seed_word = 32'h10 + {29'b0, seed_idx};

  // Core stand-in: the n-th step yields A0+n on the following cycle.
  int unsigned  core_n   = 0;
  logic [W-1:0] core_nxt = '0;
  always @(negedge clk) begin
    if (core_step === 1'b1) begin
      core_nxt = 32'hA0 + core_n;
      core_n++;
    end
  end
  always @(posedge clk) core_rand <= core_nxt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: seeding countdown, transfer stage, round-robin pointer.
  bit           m_seeded;
  int           m_seed_left;
  int           m_stage;  // 0 none, 1 stepping, 2 delivering
  int           m_winner;
  int           m_last;
  bit           m_pending;
  logic [W-1:0] m_rdata;
  logic [W-1:0] m_cur = '0;
  int unsigned  m_steps = 0;

  function automatic void model_reset();
    m_seeded    = 1'b0;
    m_seed_left = 0;
    m_stage     = 0;
    m_winner    = 0;
    m_last      = N - 1;
    m_pending   = 1'b0;
    m_rdata     = '0;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] rq, input int last);
    for (int i = 1; i <= N; i++) begin
      if (rq[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic ss, input logic [N-1:0] rq);
    int p;
    if (m_seed_left > 0) begin
      m_seed_left--;
      if (m_seed_left == 0) m_seeded = 1'b1;
    end else if (m_stage == 1) begin
      m_cur = 32'hA0 + m_steps;
      m_steps++;
      m_stage = 2;
      if (ss) m_pending = 1'b1;
    end else if (m_stage == 2) begin
      m_rdata = m_cur;
      m_last  = m_winner;
      m_stage = 0;
      if (ss) m_pending = 1'b1;
    end else if (!m_seeded) begin
      if (ss) m_seed_left = NS;
    end else if (ss || m_pending) begin
      m_seed_left = NS;
      m_pending   = 1'b0;
    end else begin
      p = rr_pick(rq, m_last);
      if (p >= 0) begin
        m_winner = p;
        m_stage  = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic         el, ev;
    logic [31:0]  eidx;
    logic [N-1:0] eg;
    el   = (m_seed_left > 0);
    eidx = el ? 32'(NS - m_seed_left) : 32'd0;
    ev   = (m_stage == 2);
    eg   = ev ? N'(1 << m_winner) : '0;
    chk("core_load", core_load, el);
    chk("seed_idx", seed_idx, eidx);
    chk("core_step", core_step, m_stage == 1);
    chk("rvalid", rvalid, ev);
    chk("gnt", gnt, eg);
    chk("rdata", rdata, ev ? m_cur : m_rdata);
    chk("seeded", seeded, m_seeded);
    chk("busy", busy, el || (m_stage != 0));
    chk("load_step_excl", core_load & core_step, 0);
    if (!rst) model_step(seed_start, req);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 20) begin
      cyc();
      k++;
    end
    chk("idle_timeout", k < 20, 1);
  endtask

  logic [3:0]  cap_g[8];
  logic [31:0] cap_d[8];
  int          cap_t[8];
  logic [3:0]  lit_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int ncap;
    int loads;
    bit found;
    seed_start = 1'b0;
    req        = '0;
    model_reset();
    #1 rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_seeded", seeded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);

    // Unseeded: requests are ignored.
    req = 4'b1111;
    repeat (20) begin
      cyc();
      chk("unseeded_gnt", gnt, 0);
      chk("unseeded_rvalid", rvalid, 0);
      chk("unseeded_seeded", seeded, 0);
    end

    // Seed load, requests still held.
    seed_start = 1'b1;
    cyc();
    seed_start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      chk("seed_load", core_load, 1);
      chk("seed_idx_seq", seed_idx, k);
      cyc();
    end
    chk("seed_done_load", core_load, 0);
    chk("seed_done_seeded", seeded, 1);
    chk("seed_done_busy", busy, 0);

    // Round-robin with all requesters active.
    ncap = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (rvalid === 1'b1 && ncap < 8) begin
        cap_g[ncap] = gnt;
        cap_d[ncap] = rdata;
        cap_t[ncap] = c;
        ncap++;
      end
    end
    chk("rr_count", ncap >= 5, 1);
    for (int k = 0; k < 5 && k < ncap; k++) begin
      chk("rr_gnt", cap_g[k], lit_g[k]);
      chk("rr_rdata", cap_d[k], 32'hA0 + k);
      if (k > 0) chk("rr_spacing", cap_t[k] - cap_t[k-1], 3);
    end
    req = '0;
    wait_idle();

    // Single-cycle request: grant exactly two cycles later, then nothing.
    req = 4'b0100;
    cyc();
    req = '0;
    chk("single_step", core_step, 1);
    chk("single_early", rvalid, 0);
    cyc();
    chk("single_rvalid", rvalid, 1);
    chk("single_gnt", gnt, 4'b0100);
    repeat (10) begin
      cyc();
      chk("single_no_more", rvalid, 0);
    end

    // Reseed requested while stepping: delivery completes, then a full reseed.
    req = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (core_step === 1'b1) found = 1'b1;
      else cyc();
    end
    chk("pend_found_step", found, 1);
    seed_start = 1'b1;
    cyc();
    seed_start = 1'b0;
    chk("pend_deliver", rvalid, 1);
    chk("pend_gnt", gnt, 4'b0001);
    loads = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (core_load === 1'b1) loads++;
      if (rvalid === 1'b1) found = 1'b1;
    end
    chk("pend_next_grant", found, 1);
    chk("pend_loads", loads, NS);
    chk("pend_gnt2", gnt, 4'b0001);
    req = '0;
    wait_idle();

    // Reset in the middle of a seed load.
    seed_start = 1'b1;
    cyc();
    seed_start = 1'b0;
    cyc();
    cyc();
    chk("mid_seed_idx", seed_idx, 2);
    chk("mid_seed_load", core_load, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_load", core_load, 0);
    chk("async_idx", seed_idx, 0);
    chk("async_step", core_step, 0);
    chk("async_rvalid", rvalid, 0);
    chk("async_gnt", gnt, 0);
    chk("async_rdata", rdata, 0);
    chk("async_seeded", seeded, 0);
    chk("async_busy", busy, 0);
    cyc();
    rst = 1'b0;
    req = 4'b1111;
    repeat (10) begin
      cyc();
      chk("post_rst_seeded", seeded, 0);
      chk("post_rst_load", core_load, 0);
    end

    // Randomized traffic with occasional reseeds and resets.
    repeat (400) begin
      req        = N'($urandom);
      seed_start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cyc();
    end
    rst        = 1'b0;
    seed_start = 1'b0;
    req        = '0;
    repeat (10) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/xorwow_arbiter.md
XORWOW_ARBITER -- requirements
Module: xorwow_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one xorwow core (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, random word width.
REQ-003 SHALL have parameter N_SEED, default 5, seed words loaded per reseed (state x,y,z,w,v plus counter d preset inside core).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port seed_start  input  1  one-cycle pulse requesting a reseed.
REQ-007 SHALL have port seed_word  input  DATA_W  seed word selected by seed_idx, combinational from register file.
REQ-008 SHALL have port seed_idx  output  3  index of seed word being loaded.
REQ-009 SHALL have port core_load  output  1  write seed_word into core state slot seed_idx.
REQ-010 SHALL have port core_step  output  1  advance core one xorwow step.
REQ-011 SHALL have port core_rand  input  DATA_W  core output, valid the cycle after core_step.
REQ-012 SHALL have port req  input  N_REQ  per-requester word request, level.
REQ-013 SHALL have port gnt  output  N_REQ  one-hot grant, asserted only with rvalid.
REQ-014 SHALL have port rdata  output  DATA_W  delivered random word.
REQ-015 SHALL have port rvalid  output  1  rdata valid for requester indicated by gnt.
REQ-016 SHALL have port seeded  output  1  core holds a loaded seed.
REQ-017 SHALL have port busy  output  1  state not UNSEEDED or IDLE.

Function
REQ-018 SHALL implement FSM states UNSEEDED, SEED, IDLE, STEP, DELIVER.
REQ-019 UNSEEDED: req ignored, no grant; seed_start -> SEED next cycle.
REQ-020 SEED: core_load=1 for exactly N_SEED consecutive cycles, seed_idx 0..N_SEED-1 in order; after idx N_SEED-1 -> IDLE, seeded=1.
REQ-021 IDLE: if any req bit set, select winner round-robin, register it, -> STEP; else stay.
REQ-022 Round-robin: search starts at (last_winner+1) mod N_REQ, wrapping; last_winner updates only on a grant.
REQ-023 STEP: core_step=1 for exactly one cycle, -> DELIVER.
REQ-024 DELIVER: rvalid=1, gnt=one-hot of registered winner, rdata=core_rand, one cycle, -> IDLE.
REQ-025 Latency: req sampled in IDLE at cycle t -> rvalid at cycle t+2; maximum throughput one word per 3 cycles.
REQ-026 Winner deasserting req after selection SHALL still receive the word; no cancel.
REQ-027 seed_start in STEP or DELIVER SHALL be latched pending; on return to IDLE pending reseed takes priority over req -> SEED.
REQ-028 seed_start during SEED SHALL be ignored (no restart, not latched).
REQ-029 seed_start in IDLE -> SEED next cycle, even if req is set that cycle.
REQ-030 During SEED from seeded state, seeded SHALL remain 1; no grants issued.
REQ-031 core_load and core_step SHALL never be asserted in the same cycle.
REQ-032 gnt SHALL be zero whenever rvalid=0; rdata SHALL hold its last value when rvalid=0.

Reset
REQ-033 On reset assertion, immediately and asynchronously: state=UNSEEDED, seeded=0, busy=0, core_load=0, core_step=0, rvalid=0, gnt=0, rdata=0, seed_idx=0, last_winner=N_REQ-1, pending reseed cleared.
REQ-034 Reset asserted mid-SEED or mid-STEP SHALL abort without further core_load/core_step; after release, the block SHALL stay UNSEEDED until seed_start.

Verification
REQ-035 Reset release, req=4'b1111, no seed_start for 20 cycles -> gnt=0, rvalid=0, seeded=0 throughout.
REQ-036 seed_start pulse, seed_word=32'h10+seed_idx -> core_load high 5 cycles, seed_idx 0,1,2,3,4, then seeded=1, busy=0.
REQ-037 Seeded, req=4'b1111 held, core model returns 32'hA0+n on step n -> gnt sequence 0001,0010,0100,1000,0001 with rdata A0,A1,A2,A3,A4, each rvalid 3 cycles apart.
REQ-038 Seeded, req=4'b0100 one cycle in IDLE then 0 -> rvalid and gnt=0100 exactly 2 cycles later; no further grants.
REQ-039 seed_start during STEP with req=4'b0001 held -> DELIVER completes to requester 0, then SEED (5 loads) before next grant.
REQ-040 reset pulsed during SEED at seed_idx=2 -> all outputs zero at once, no further core_load; seeded=0 until next seed_start.
